mesh_switch_control: RTL
========================

MESH_SWITCH_CONTROL -- requirements
Module: mesh_switch_control

Interface
REQ-001 The block SHALL have parameter RADIX, default 5, giving the number of ports, ordered [core, north, east, south, west].
REQ-002 The block SHALL have parameter CREDITS, default 4, giving the downstream buffer depth per output.
REQ-003 The block SHALL have port clk, input, 1 bit, the clock.
REQ-004 The block SHALL have port reset_n, input, 1 bit, the reset: synchronous, active-low.
REQ-005 The block SHALL have port i_request, input, [0:RADIX-1][0:RADIX-1], giving per input a onehot requested output (index 0 = core).
REQ-006 The block SHALL have port i_credit, input, [0:RADIX-1], a one-cycle pulse per output returning one downstream slot.
REQ-007 The block SHALL have port i_en, input, [0:RADIX-1], per-output downstream-ready, used only when credits are compiled out.
REQ-008 The block SHALL have port o_grant, output, [0:RADIX-1][0:RADIX-1], per input a onehot output select in the switch i_sel format.
REQ-009 The block SHALL have port o_pop, output, [0:RADIX-1], a per-input dequeue strobe for the local input FIFO.

Function
REQ-010 Arbitration SHALL be registered, so a request sampled at edge N produces o_grant and o_pop valid after edge N+1, a latency of 1 cycle.
REQ-011 Each output SHALL grant at most one input per cycle, using an independent round-robin pointer.
REQ-012 On a grant, the pointer SHALL advance to winner+1 modulo RADIX; with no grant the pointer SHALL hold.
REQ-013 The round-robin search SHALL start at the pointer and wrap from RADIX-1 to 0.
REQ-014 A request that is not onehot (zero or more than one bit set) SHALL be ignored and SHALL never be granted.
REQ-015 o_pop[i] SHALL equal the OR of o_grant[i] in the same cycle.
REQ-016 o_grant[i] SHALL be zero or onehot.
REQ-017 An input SHALL hold its request until it sees o_pop.
REQ-018 The block SHALL mask, for one cycle, any request from an input whose o_pop is currently high, which prevents a double grant of a stale FIFO head.
REQ-019 An output SHALL be eligible only if it has credit>0 (credit mode) or i_en is high (non-credit mode).

Reset
REQ-020 While reset_n=0 at a clk edge, o_grant SHALL be all zero and o_pop SHALL be all zero.
REQ-021 While reset_n=0 at a clk edge, every round-robin pointer SHALL be set to 0.
REQ-022 While reset_n=0 at a clk edge, every credit counter SHALL be set to CREDITS.
REQ-023 A reset asserted mid-operation SHALL discard pending grants and return credits to full on the next edge.

Configuration
REQ-024 With macro MESH_SWCTRL_CREDIT_EN defined, the block SHALL keep one credit counter per output, of width $clog2(CREDITS+1).
REQ-025 With MESH_SWCTRL_CREDIT_EN defined, a grant SHALL decrement the counter, an i_credit pulse SHALL increment it, and both together SHALL leave it unchanged.
REQ-026 With MESH_SWCTRL_CREDIT_EN defined, an i_credit pulse while the counter equals CREDITS SHALL be ignored (saturate).
REQ-027 With MESH_SWCTRL_CREDIT_EN defined, i_en SHALL be unused.
REQ-028 Without MESH_SWCTRL_CREDIT_EN, the credit counters SHALL be absent, eligibility SHALL be i_en sampled at the arbitration edge, and i_credit SHALL be unused.

Structure
REQ-029 Shared package mesh_pkg SHALL hold the port index enum (CORE=0, NORTH, EAST, SOUTH, WEST) and the RADIX constant.
REQ-030 The design SHALL contain sub-module mesh_rr_arbiter (request vector in, onehot grant out, registered pointer), instantiated once per output.
REQ-031 The top level SHALL transpose the per-output grants into the per-input o_grant array.

Verification
REQ-032 Single request: input 1 requests output EAST (00100) -> o_grant[1]=00100 and o_pop[1]=1 one cycle later, pulsing for one cycle.
REQ-033 Contention: inputs 0, 2 and 4 hold requests for output 0 with the pointer at 0 -> grants go to 0, 2, 4, 0 on successive grant cycles.
REQ-034 Credit exhaustion (credit mode, CREDITS=4): input 3 requests CORE continuously with no i_credit -> exactly 4 grants, then none; one i_credit pulse -> exactly one more grant.
REQ-035 Simultaneous grant and credit on the same output at the same edge -> counter unchanged; a credit at full -> counter stays 4.
REQ-036 Invalid request: i_request[2]=01100 -> no grant ever to input 2; a concurrent valid request from input 0 is still served.
REQ-037 Reset mid-stream: reset_n=0 for one edge during contention -> o_grant all zero, pointers 0, credits 4, and the first grant after reset goes to the lowest requester.

Source files
------------

// File: rtl/mesh_pkg.sv
// mesh_pkg: shared definitions for the mesh router switch control slice.
// Holds the port index ordering and the default router radix.
package mesh_pkg;

    // Number of router ports: core plus the four compass directions.
    localparam int unsigned RADIX = 5;

    // Port index ordering shared by request, grant and credit vectors.
    typedef enum logic [2:0] {
        CORE  = 3'd0,
        NORTH = 3'd1,
        EAST  = 3'd2,
        SOUTH = 3'd3,
        WEST  = 3'd4
    } port_e;

endpackage : mesh_pkg

// File: rtl/mesh_rr_arbiter.sv
// mesh_rr_arbiter: round-robin arbiter for one output port.
// The search starts at the registered pointer and wraps; on a grant the pointer moves to
// winner+1, otherwise it holds. The grant itself is combinational; the caller registers it.
module mesh_rr_arbiter
    import mesh_pkg::*;
#(
    parameter int unsigned NUM_REQ = 5
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [0:NUM_REQ-1] i_req,
    input  logic               i_en,
    output logic [0:NUM_REQ-1] o_grant
);

    localparam int unsigned PtrW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [PtrW-1:0] PtrLast = PtrW'(NUM_REQ - 1);

    logic [PtrW-1:0] r_ptr;
    logic            w_found;
    logic [PtrW-1:0] w_winner;

    // Pick the first requester at or after the pointer, wrapping past the last index.
    always_comb begin
        int unsigned idx;
        idx      = 0;
        o_grant  = '0;
        w_found  = 1'b0;
        w_winner = '0;
        if (i_en) begin
            for (int unsigned k = 0; k < NUM_REQ; k++) begin
                idx = (32'(r_ptr) + k) % NUM_REQ;
                if (!w_found && i_req[idx]) begin
                    w_found      = 1'b1;
                    w_winner     = PtrW'(idx);
                    o_grant[idx] = 1'b1;
                end
            end
        end
    end

    // Advance the pointer past the winner; hold it when nothing is granted.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_ptr <= '0;
        end else if (w_found) begin
            r_ptr <= (w_winner == PtrLast) ? '0 : w_winner + 1'b1;
        end
    end

endmodule : mesh_rr_arbiter

// File: rtl/mesh_switch_control.sv
// mesh_switch_control: registered crossbar arbitration for a mesh router.
// One round-robin arbiter per output; grants are transposed to a per-input select and
// registered, and o_pop strobes the winning input FIFO. Optional macro
// MESH_SWCTRL_CREDIT_EN replaces i_en gating with per-output downstream credit counters.
module mesh_switch_control
    import mesh_pkg::*;
#(
    parameter int unsigned RADIX   = mesh_pkg::RADIX,
    parameter int unsigned CREDITS = 4
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [0:RADIX-1][0:RADIX-1] i_request,
    input  logic [0:RADIX-1]            i_credit,
    input  logic [0:RADIX-1]            i_en,
    output logic [0:RADIX-1][0:RADIX-1] o_grant,
    output logic [0:RADIX-1]            o_pop
);

    logic [0:RADIX-1][0:RADIX-1] r_grant;       // [input][output]
    logic [0:RADIX-1]            w_pop;
    logic [0:RADIX-1]            w_valid;
    logic [0:RADIX-1][0:RADIX-1] w_req_by_out;  // [output][input]
    logic [0:RADIX-1][0:RADIX-1] w_gnt_by_out;  // [output][input]
    logic [0:RADIX-1][0:RADIX-1] w_gnt_by_in;   // [input][output]
    logic [0:RADIX-1]            w_eligible;

    // An input pops its FIFO in any cycle where its registered grant row is non-zero.
    always_comb begin
        w_pop = '0;
        for (int i = 0; i < RADIX; i++) begin
            w_pop[i] = |r_grant[i];
        end
    end

    // Drop non-onehot requests and requests whose FIFO head is being popped this cycle.
    always_comb begin
        w_valid      = '0;
        w_req_by_out = '0;
        for (int i = 0; i < RADIX; i++) begin
            w_valid[i] = ($countones(i_request[i]) == 1);
        end
        for (int o = 0; o < RADIX; o++) begin
            for (int i = 0; i < RADIX; i++) begin
                w_req_by_out[o][i] = w_valid[i] & ~w_pop[i] & i_request[i][o];
            end
        end
    end

    for (genvar g = 0; g < RADIX; g++) begin : gen_out
        mesh_rr_arbiter #(
            .NUM_REQ (RADIX)
        ) u_arb (
            .clk     (clk),
            .reset_n (reset_n),
            .i_req   (w_req_by_out[g]),
            .i_en    (w_eligible[g]),
            .o_grant (w_gnt_by_out[g])
        );
    end

    // Turn per-output winners into the per-input output select.
    always_comb begin
        w_gnt_by_in = '0;
        for (int i = 0; i < RADIX; i++) begin
            for (int o = 0; o < RADIX; o++) begin
                w_gnt_by_in[i][o] = w_gnt_by_out[o][i];
            end
        end
    end

    // Register the arbitration result; reset discards any pending grant.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_grant <= '0;
        end else begin
            r_grant <= w_gnt_by_in;
        end
    end

`ifdef MESH_SWCTRL_CREDIT_EN
    localparam int unsigned CntW = $clog2(CREDITS + 1);
    localparam logic [CntW-1:0] CreditFull = CntW'(CREDITS);

    logic [0:RADIX-1][CntW-1:0] r_credit;
    logic [0:RADIX-1]           w_out_granted;
    logic                       w_unused_en;

    assign w_unused_en = ^i_en;

    // An output consumes a downstream slot whenever its arbiter picks a winner.
    always_comb begin
        w_out_granted = '0;
        w_eligible    = '0;
        for (int o = 0; o < RADIX; o++) begin
            w_out_granted[o] = |w_gnt_by_out[o];
            w_eligible[o]    = (r_credit[o] != '0);
        end
    end

    // Grant and returned credit cancel; a credit at full is treated as spurious.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int o = 0; o < RADIX; o++) begin
                r_credit[o] <= CreditFull;
            end
        end else begin
            for (int o = 0; o < RADIX; o++) begin
                if (w_out_granted[o] && !i_credit[o]) begin
                    r_credit[o] <= r_credit[o] - 1'b1;
                end else if (!w_out_granted[o] && i_credit[o] && (r_credit[o] != CreditFull)) begin
                    r_credit[o] <= r_credit[o] + 1'b1;
                end
            end
        end
    end
`else
    logic w_unused_credit;

    assign w_unused_credit = ^i_credit;
    assign w_eligible      = i_en;
`endif

    assign o_grant = r_grant;
    assign o_pop   = w_pop;

endmodule : mesh_switch_control
